// File: rtl/mmp_iddmm_finalsub_if.sv
// ---------------------------------------------------------------------------
// mmp_iddmm_finalsub_if
// Signal bundle between the IDDMM final-subtraction stage and its
// environment: the PE controller (comp_req/ref_an in, comp_end/busy out) and
// the A/M word RAMs (shared read port, A RAM write port).
//
//   comp_req  controller -> stage   level request, held until comp_end
//   ref_an    controller -> stage   top carry bit of A
//   comp_end  stage -> controller   one-cycle completion pulse
//   busy      stage -> controller   operation in progress
//   rd_ena    stage -> RAMs         read strobe (A and M)
//   rd_addr   stage -> RAMs         read word address
//   a_rdata   A RAM -> stage        read data, 1-cycle latency
//   m_rdata   M RAM -> stage        read data, 1-cycle latency
//   wr_ena    stage -> A RAM        write strobe
//   wr_addr   stage -> A RAM        write word address
//   wr_data   stage -> A RAM        write data
//
// master: controller/RAM side.  slave: the final-subtraction stage.
// ---------------------------------------------------------------------------
interface mmp_iddmm_finalsub_if #(
  parameter int N      = 32,
  parameter int K      = 128,
  parameter int ADDR_W = $clog2(N)
);
  logic              comp_req;
  logic              ref_an;
  logic              comp_end;
  logic              busy;
  logic              rd_ena;
  logic [ADDR_W-1:0] rd_addr;
  logic [K-1:0]      a_rdata;
  logic [K-1:0]      m_rdata;
  logic              wr_ena;
  logic [ADDR_W-1:0] wr_addr;
  logic [K-1:0]      wr_data;

  modport master (
    output comp_req, ref_an, a_rdata, m_rdata,
    input  comp_end, busy, rd_ena, rd_addr, wr_ena, wr_addr, wr_data
  );

  modport slave (
    input  comp_req, ref_an, a_rdata, m_rdata,
    output comp_end, busy, rd_ena, rd_addr, wr_ena, wr_addr, wr_data
  );
endinterface

// File: rtl/mmp_iddmm_finalsub.sv
// ---------------------------------------------------------------------------
// mmp_iddmm_finalsub
// Final conditional subtraction of the IDDMM Montgomery multiplier.
// On an accepted request it streams A and M out of their RAMs word by word,
// forms D = {an,A} - M with a rippling borrow, buffers the difference words,
// and, when D >= 0, writes D back over A. comp_end pulses once at the end.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   mmp_iddmm_finalsub_if.slave (handshake, RAM read/write ports)
//
// Build option:
//   MMP_IDDMM_FINALSUB_CT_EN  constant-time mode. The write-back phase is
//   always executed; it writes either D or the original A (kept in a second
//   buffer), so latency is 2N+4 regardless of data. Without the macro the
//   no-subtract case skips write-back (latency N+3).
//
// Timeline (cycle 0 = cycle in which the request is sampled in IDLE):
//   SUB 1..N, DRAIN N+1, DECIDE N+2, WB N+3..2N+3 (writes in its last N
//   cycles), DONE 2N+4. No-subtract (default build): DONE at N+3.
// ---------------------------------------------------------------------------
module mmp_iddmm_finalsub #(
  parameter int N      = 32,
  parameter int K      = 128,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  mmp_iddmm_finalsub_if.slave     bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST_RD = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_WB_END  = CNT_W'(N);

  typedef enum logic [2:0] {
    IDLE,
    SUB,
    DRAIN,
    DECIDE,
    WB,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              armed_q;
  logic              an_q;
  logic              borrow_q;
  logic              accept;
  logic              sel_now;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [K:0]        sub_p1;

  logic              wr_ena_p2;
  logic [ADDR_W-1:0] wr_addr_p2;
  logic [K-1:0]      wr_data_p2;
  logic              wb_issue;
  logic [ADDR_W-1:0] wb_idx;

  logic [K-1:0]      dbuf [N];

`ifdef MMP_IDDMM_FINALSUB_CT_EN
  logic [K-1:0]      abuf [N];
  logic              sel_q;
`endif

  // One word of the subtraction: result bit K is the outgoing borrow.
  function automatic logic [K:0] sub_word(input logic [K-1:0] a,
                                          input logic [K-1:0] m,
                                          input logic         b);
    return {1'b0, a} - {1'b0, m} - {{K{1'b0}}, b};
  endfunction

  assign accept  = (state_q == IDLE) && bus.comp_req && armed_q;
  // D >= 0 exactly when the top carry is set or A >= M produced no borrow.
  assign sel_now = an_q | ~borrow_q;

  // ---------------- control: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = SUB;
      SUB:    if (cnt_q == CNT_LAST_RD) state_d = DRAIN;
      DRAIN:  state_d = DECIDE;
`ifdef MMP_IDDMM_FINALSUB_CT_EN
      DECIDE: state_d = WB;
`else
      DECIDE: state_d = sel_now ? WB : DONE;
`endif
      WB:     if (cnt_q == CNT_WB_END) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Word counter: read address in SUB, write-back slot in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        SUB:     cnt_q <= (cnt_q == CNT_LAST_RD) ? '0 : cnt_q + 1'b1;
        WB:      cnt_q <= cnt_q + 1'b1;
        default: cnt_q <= '0;
      endcase
    end
  end

  // armed blocks a second run from the same held request; any low sample
  // of comp_req re-arms, and that takes priority over the DONE clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b1;
      an_q    <= 1'b0;
    end else begin
      if (state_q == DONE) armed_q <= 1'b0;
      if (!bus.comp_req)   armed_q <= 1'b1;
      if (accept)          an_q    <= bus.ref_an;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.comp_end = (state_q == DONE);
  assign bus.rd_ena   = (state_q == SUB);
  assign bus.rd_addr  = (state_q == SUB) ? cnt_q[ADDR_W-1:0] : '0;

  // ---------------- p1: RAM data returns, subtract one word ----------------
  assign sub_p1 = sub_word(bus.a_rdata, bus.m_rdata, borrow_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      vld_p1 <= bus.rd_ena;
      if (accept)      borrow_q <= 1'b0;
      else if (vld_p1) borrow_q <= sub_p1[K];
    end
  end

  always_ff @(posedge clk) begin
    addr_p1 <= bus.rd_addr;
    if (vld_p1) dbuf[addr_p1] <= sub_p1[K-1:0];
  end

`ifdef MMP_IDDMM_FINALSUB_CT_EN
  always_ff @(posedge clk) begin
    if (vld_p1) abuf[addr_p1] <= bus.a_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     sel_q <= 1'b0;
    else if (state_q == DECIDE)  sel_q <= sel_now;
  end
`endif

  // ---------------- p2: registered buffer read, A RAM write port ----------------
  // The first WB cycle only fetches word 0, so the write strobe covers the
  // last N cycles of WB and never overlaps the read strobe.
  assign wb_issue = (state_q == WB) && (cnt_q != CNT_WB_END);
  assign wb_idx   = cnt_q[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ena_p2  <= 1'b0;
      wr_addr_p2 <= '0;
      wr_data_p2 <= '0;
    end else begin
      wr_ena_p2 <= wb_issue;
      if (wb_issue) begin
        wr_addr_p2 <= wb_idx;
`ifdef MMP_IDDMM_FINALSUB_CT_EN
        wr_data_p2 <= sel_q ? dbuf[wb_idx] : abuf[wb_idx];
`else
        wr_data_p2 <= dbuf[wb_idx];
`endif
      end
    end
  end

  assign bus.wr_ena  = wr_ena_p2;
  assign bus.wr_addr = wr_addr_p2;
  assign bus.wr_data = wr_data_p2;

endmodule

// File: doc/mmp_iddmm_finalsub.md
Name: mmp_iddmm_finalsub

Overview:
- Final conditional-subtraction stage of the IDDMM Montgomery multiplier. It is the consumer of the PE controller's comp_req/comp_end handshake.
- Once the PE array has written the N-word intermediate A to the A RAM and latched the top carry (ref_an), this block computes D = {an,A} - M word-serially.
- If D is non-negative, it overwrites the A RAM with D; then it signals comp_end. The A RAM then holds the reduced Montgomery product.

Parameters:
- N, 32, number of K-bit words per operand.
- K, 128, word width in bits.
- ADDR_W, $clog2(N), word address width.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- comp_req  input  1  level request from controller; held high until comp_end is seen.
- ref_an  input  1  top carry bit of A; valid whenever comp_req is high.
- comp_end  output  1  single-cycle completion pulse.
- rd_ena  output  1  read strobe to A RAM and M RAM.
- rd_addr  output  ADDR_W  word address for A and M reads.
- a_rdata  input  K  A RAM read data, 1-cycle latency after rd_ena.
- m_rdata  input  K  M RAM read data, 1-cycle latency after rd_ena.
- wr_ena  output  1  A RAM write strobe.
- wr_addr  output  ADDR_W  A RAM write address.
- wr_data  output  K  A RAM write data.
- busy  output  1  high from request acceptance until comp_end, inclusive.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: comp_end=0, rd_ena=0, rd_addr=0, wr_ena=0, wr_addr=0, wr_data=0, busy=0. State = IDLE, borrow=0, armed=1.
- IDLE:
  - comp_req=1 and armed=1 → SUB. Latch ref_an into an_r, clear borrow, set busy.
  - comp_req=1 and armed=0 → stay in IDLE.
- SUB (N cycles):
  - rd_ena=1, rd_addr=0..N-1 ascending, one per cycle.
  - One cycle after each read: {borrow, diff_k} = a_rdata - m_rdata - borrow (K+1-bit arithmetic). diff_k is stored into internal buffer DBUF[k].
- DRAIN (1 cycle): the last word is processed. rd_ena=0.
- DECIDE (1 cycle): sel_sub = an_r | ~borrow.
  - sel_sub=1 → WB.
  - sel_sub=0 → DONE. Non-CT build only; see Optional Feature.
- WB (N+1 cycles):
  - DBUF read is registered.
  - wr_ena=1 for exactly N consecutive cycles, with wr_addr=0..N-1 and wr_data=DBUF[wr_addr].
- DONE (1 cycle): comp_end=1 and busy stays high. Next state is IDLE with armed=0.
- Re-arm: armed returns to 1 in any cycle comp_req=0 is sampled. This prevents a restart from the same held request.
- Latency, request-accept to comp_end:
  - Subtract path: N+N+4 cycles.
  - No-subtract path (non-CT): N+3 cycles.
- comp_req is ignored while busy; dropping it mid-operation does not abort.
- rd_ena and wr_ena are never high in the same cycle.
- Correctness: for inputs {an,A} < 2M, the result A mod 2^(N·K) from D is exact. Behaviour for inputs ≥ 2M is unspecified.
- rst asserted mid-operation: immediate return to reset values. Any partial write-back is abandoned, and the A RAM contents are undefined.

Optional Feature:
- Macro: MMP_IDDMM_FINALSUB_CT_EN (constant-time mode).
- Defined:
  - DECIDE always enters WB.
  - For each word, wr_data = sel_sub ? DBUF[k] : A word. The A word is re-supplied via a second buffer ABUF filled during SUB.
  - Latency is always 2N+4 cycles and is independent of data.
- Undefined: ABUF is not built, and the no-subtract path skips WB.

Test Plan:
- N=4, K=8, A={0x10,0,0,0x80} (word0 first), M={0x01,0,0,0x80}, an=0 → comp_end at cycle 12. Writes, word0..3: 0x0F, 0x00, 0x00, 0x00.
- Same M, A={0x00,0,0,0x70}, an=0 → borrow=1, no writes, comp_end at cycle 7 (non-CT). CT build: 4 writes of the original A, comp_end at cycle 12.
- an=1, A={0x05,0,0,0x10}, M={0x07,0,0,0x80} → subtract forced. Result {0xFE,0xFF,0xFF,0x8F} written.
- Borrow chain: A={0,0,0,0xFF}, M={1,0,0,0x01} → writes {0xFF,0xFF,0xFF,0xFD}.
- comp_req held high for 20 cycles after comp_end → exactly one operation. Drop comp_req for 1 cycle, raise again → second operation starts.
- rst pulsed at cycle 5 of SUB → all outputs 0 next edge. A later comp_req completes normally.
